// File: rtl/seq_capture_check.sv
// seq_capture_check: captures a player's colour entries per round, optionally
// checking each against a reference, with a per-entry inactivity timeout.
module seq_capture_check #(
  parameter int COLOUR_W = 2,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int LEN_W = $clog2(MAX_LEN + 1),
  localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         colour_in,
  input  logic [COLOUR_W-1:0]          colour_val,
  input  logic [LEN_W-1:0]             sequence_len,
  input  logic                         check_en,
  input  logic [MAX_LEN*COLOUR_W-1:0]  expected_seq,
  output logic                         busy,
  output logic                         complete,
  output logic                         match,
  output logic                         mismatch,
  output logic                         timeout,
  output logic [LEN_W-1:0]             count,
  output logic [MAX_LEN*COLOUR_W-1:0]  sequence_val
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state;
  logic prev;
  logic [LEN_W-1:0] len, len_clip, count_nx;
  logic [TW-1:0] timer, timer_nx;
  logic accept, bad;
  always_comb begin
    len_clip = sequence_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : sequence_len;
    accept = colour_in && !prev;
    count_nx = count + LEN_W'(1);
    timer_nx = timer + TW'(1);
    bad = check_en && colour_val != expected_seq[count*COLOUR_W +: COLOUR_W];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prev <= 1'b0;
      len <= '0;
      count <= '0;
      timer <= '0;
      sequence_val <= '0;
      busy <= 1'b0;
      complete <= 1'b0;
      match <= 1'b0;
      mismatch <= 1'b0;
      timeout <= 1'b0;
    end else begin
      prev <= colour_in;
      case (state)
        IDLE: if (en) begin
          len <= len_clip;
          sequence_val <= '0;
          count <= '0;
          timer <= '0;
          mismatch <= 1'b0;
          timeout <= 1'b0;
          match <= len_clip == '0;
          complete <= len_clip == '0;
          busy <= len_clip != '0;
          state <= len_clip == '0 ? DONE : CAPTURE;
        end
        CAPTURE: if (!en) begin
          state <= IDLE;
          busy <= 1'b0;
          count <= '0;
          sequence_val <= '0;
          match <= 1'b0;
          mismatch <= 1'b0;
          timeout <= 1'b0;
        end else if (accept) begin
          // accept takes priority over a timeout expiring on the same cycle
          sequence_val[count*COLOUR_W +: COLOUR_W] <= colour_val;
          count <= count_nx;
          timer <= '0;
          if (bad || count_nx == len) begin
            state <= DONE;
            busy <= 1'b0;
            complete <= 1'b1;
            mismatch <= bad;
            match <= !bad;
          end
        end else begin
          timer <= timer_nx;
          if (timer_nx == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            complete <= 1'b1;
            timeout <= 1'b1;
          end
        end
        DONE: if (!en) begin
          state <= IDLE;
          complete <= 1'b0;
          match <= 1'b0;
          mismatch <= 1'b0;
          timeout <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
